// File: rtl/uop_cache_pkg.sv
// Shared types and defaults for the loop-buffer micro-op cache arbiter.
// Holds the entry geometry, the FSM state encoding and the grant-owner encoding.
package uop_cache_pkg;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int DATA_W = 32;

  typedef enum logic {
    ACTIVE = 1'b0,
    FLUSH  = 1'b1
  } state_e;

  typedef enum logic {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter that keeps its own last-grant register.
// Ports: clk/reset, en_i gates all grants, req0_i (FILL) / req1_i (REPLAY)
// are the requests, gnt0_o / gnt1_o are the one-hot combinational grants.
module rr_arb2
  import uop_cache_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  owner_e last_q, last_d;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (en_i) begin
      if (req0_i && req1_i) begin
        if (last_q == REPLAY) gnt0_o = 1'b1;
        else                  gnt1_o = 1'b1;
      end else if (req0_i) begin
        gnt0_o = 1'b1;
      end else if (req1_i) begin
        gnt1_o = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt0_o)      last_d = FILL;
    else if (gnt1_o) last_d = REPLAY;
  end

  // Starting at REPLAY lets fill win the first tie.
  always_ff @(posedge clk) begin
    if (reset) last_q <= REPLAY;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/uop_cache_arbiter.sv
// Single-port BRAM access controller for the loop-buffer micro-op cache.
// Ports: fill_* write path, rep_* replay read path, rsp_* replay response,
// flush_req/flush_ack/busy invalidate-all handshake, mem_* external BRAM port.
module uop_cache_arbiter #(
  parameter int ADDR_W = uop_cache_pkg::ADDR_W,
  parameter int DEPTH  = 1 << ADDR_W,
  parameter int DATA_W = uop_cache_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_gnt,
  input  logic              rep_req,
  input  logic [ADDR_W-1:0] rep_addr,
  output logic              rep_gnt,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              flush_req,
  output logic              flush_ack,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import uop_cache_pkg::*;

  state_e             state_q, state_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic               rsp_valid_q;
  logic               rsp_hit_q;
  logic               arb_en;

  // Flush has absolute priority: a pending flush_req blocks both grants.
  assign arb_en = !reset && (state_q == ACTIVE) && !flush_req;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .en_i   (arb_en),
    .req0_i (fill_req),
    .req1_i (rep_req),
    .gnt0_o (fill_gnt),
    .gnt1_o (rep_gnt)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    unique case (state_q)
      ACTIVE: begin
        if (flush_req) state_d = FLUSH;
        if (fill_gnt)  valid_d[fill_addr] = 1'b1;
      end
      FLUSH: begin
        state_d = ACTIVE;
        valid_d = '0;
      end
      default: state_d = ACTIVE;
    endcase
  end

  assign mem_en    = fill_gnt | rep_gnt;
  assign mem_we    = fill_gnt;
  assign mem_addr  = fill_gnt ? fill_addr :
                     rep_gnt  ? rep_addr  : '0;
  assign mem_wdata = fill_gnt ? fill_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACTIVE;
      valid_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      rsp_valid_q <= rep_gnt;
      rsp_hit_q   <= rep_gnt & valid_q[rep_addr];
    end
  end

  // Outputs are forced low while reset is held so an in-flight
  // response is dropped rather than leaking out during reset.
  assign rsp_valid = rsp_valid_q & !reset;
  assign rsp_hit   = rsp_hit_q & !reset;
  assign rsp_data  = rsp_hit ? mem_rdata : '0;
  assign busy      = (state_q == FLUSH) && !reset;
  assign flush_ack = busy;

endmodule

// File: tb/tb_uop_cache_arbiter.sv
// Self-checking bench for uop_cache_arbiter with a behavioural BRAM.
// Replay responses are checked against a scoreboard queue.
module tb_uop_cache_arbiter;

  localparam int AW = 3;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          fill_req;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data;
  logic          fill_gnt;
  logic          rep_req;
  logic [AW-1:0] rep_addr;
  logic          rep_gnt;
  logic          rsp_valid;
  logic          rsp_hit;
  logic [DW-1:0] rsp_data;
  logic          flush_req;
  logic          flush_ack;
  logic          busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] bram [8];
  logic          ref_valid [8];
  logic [DW-1:0] ref_mem [8];
  logic [DW:0]   sb_q [$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uop_cache_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .fill_req  (fill_req),
    .fill_addr (fill_addr),
    .fill_data (fill_data),
    .fill_gnt  (fill_gnt),
    .rep_req   (rep_req),
    .rep_addr  (rep_addr),
    .rep_gnt   (rep_gnt),
    .rsp_valid (rsp_valid),
    .rsp_hit   (rsp_hit),
    .rsp_data  (rsp_data),
    .flush_req (flush_req),
    .flush_ack (flush_ack),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr];
    end
  end

  always @(negedge clk) begin
    logic [DW:0] e;
    if (rsp_valid === 1'b1) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected got hit=%b data=%h", rsp_hit, rsp_data);
      end else begin
        e = sb_q.pop_front();
        if ({rsp_hit, rsp_data} !== e) begin
          bad++;
          $display("FAIL rsp got hit=%b data=%h exp hit=%b data=%h",
                   rsp_hit, rsp_data, e[DW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fill_req  = 1'b0;
    rep_req   = 1'b0;
    flush_req = 1'b0;
    fill_addr = '0;
    fill_data = '0;
    rep_addr  = '0;
  endtask

  task automatic clr_ref();
    for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    clr_ref();
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({fill_gnt, rep_gnt, mem_en, mem_we, rsp_valid,
         rsp_hit, flush_ack, busy} !== 8'h00) begin
      bad++;
      $display("FAIL reset_ctl got=%b exp=00000000",
               {fill_gnt, rep_gnt, mem_en, mem_we, rsp_valid,
                rsp_hit, flush_ack, busy});
    end
    total++;
    if (mem_addr !== '0 || mem_wdata !== '0 || rsp_data !== '0) begin
      bad++;
      $display("FAIL reset_data got addr=%h wdata=%h rdata=%h exp 0",
               mem_addr, mem_wdata, rsp_data);
    end
    tick();
  endtask

  task automatic test_fill_replay();
    fill_req  = 1'b1;
    fill_addr = 3'd2;
    fill_data = 32'h00A0_0093;
    @(negedge clk);
    total++;
    if ({fill_gnt, rep_gnt, mem_en, mem_we} !== 4'b1011) begin
      bad++;
      $display("FAIL fill_gnt got=%b exp=1011",
               {fill_gnt, rep_gnt, mem_en, mem_we});
    end
    total++;
    if (mem_addr !== 3'd2 || mem_wdata !== 32'h00A0_0093) begin
      bad++;
      $display("FAIL fill_bus got addr=%h wdata=%h exp 2/00a00093",
               mem_addr, mem_wdata);
    end
    ref_valid[2] = 1'b1;
    ref_mem[2]   = 32'h00A0_0093;
    tick();
    fill_req = 1'b0;
    rep_req  = 1'b1;
    rep_addr = 3'd2;
    @(negedge clk);
    total++;
    if ({fill_gnt, rep_gnt, mem_en, mem_we, mem_addr} !== 7'b0110_010) begin
      bad++;
      $display("FAIL rep_gnt got=%b exp=0110010",
               {fill_gnt, rep_gnt, mem_en, mem_we, mem_addr});
    end
    sb_q.push_back({1'b1, 32'h00A0_0093});
    tick();
    idle();
    @(negedge clk);
    tick();
  endtask

  task automatic test_miss();
    rep_req  = 1'b1;
    rep_addr = 3'd5;
    @(negedge clk);
    total++;
    if (rep_gnt !== 1'b1 || mem_addr !== 3'd5 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL miss_gnt got gnt=%b addr=%h we=%b exp 1/5/0",
               rep_gnt, mem_addr, mem_we);
    end
    sb_q.push_back({1'b0, 32'h0});
    tick();
    idle();
    @(negedge clk);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    logic          exp_f;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clr_ref();
    rep_req  = 1'b1;
    rep_addr = 3'd4;
    fill_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d         = $urandom;
      fill_addr = 3'(4 + i / 2);
      fill_data = d;
      exp_f     = (i % 2) == 0;
      @(negedge clk);
      total++;
      if ({fill_gnt, rep_gnt} !== {exp_f, !exp_f}) begin
        bad++;
        $display("FAIL alt_gnt[%0d] got=%b%b exp=%b%b",
                 i, fill_gnt, rep_gnt, exp_f, !exp_f);
      end
      if (exp_f) begin
        ref_valid[fill_addr] = 1'b1;
        ref_mem[fill_addr]   = d;
      end else begin
        sb_q.push_back({ref_valid[4], ref_valid[4] ? ref_mem[4] : 32'h0});
      end
      tick();
    end
    idle();
    @(negedge clk);
    tick();
  endtask

  task automatic test_flush();
    for (int a = 1; a <= 3; a++) begin
      fill_req  = 1'b1;
      fill_addr = 3'(a);
      fill_data = 32'h1000 + 32'(a);
      @(negedge clk);
      total++;
      if (fill_gnt !== 1'b1) begin
        bad++;
        $display("FAIL flush_fill[%0d] got=%b exp=1", a, fill_gnt);
      end
      ref_valid[a] = 1'b1;
      ref_mem[a]   = fill_data;
      tick();
    end
    idle();
    rep_req   = 1'b1;
    rep_addr  = 3'd1;
    flush_req = 1'b1;
    @(negedge clk);
    total++;
    if ({fill_gnt, rep_gnt, mem_en, busy} !== 4'b0000) begin
      bad++;
      $display("FAIL flush_block got=%b exp=0000",
               {fill_gnt, rep_gnt, mem_en, busy});
    end
    tick();
    flush_req = 1'b0;
    @(negedge clk);
    total++;
    if ({flush_ack, busy, rep_gnt, mem_en} !== 4'b1100) begin
      bad++;
      $display("FAIL flush_state got=%b exp=1100",
               {flush_ack, busy, rep_gnt, mem_en});
    end
    clr_ref();
    tick();
    @(negedge clk);
    total++;
    if ({rep_gnt, flush_ack, busy} !== 3'b100) begin
      bad++;
      $display("FAIL flush_after got=%b exp=100", {rep_gnt, flush_ack, busy});
    end
    sb_q.push_back({1'b0, 32'h0});
    tick();
    idle();
    @(negedge clk);
    tick();
  endtask

  task automatic test_replay_then_flush();
    fill_req  = 1'b1;
    fill_addr = 3'd6;
    fill_data = 32'hCAFE_0006;
    @(negedge clk);
    ref_valid[6] = 1'b1;
    ref_mem[6]   = 32'hCAFE_0006;
    tick();
    idle();
    rep_req  = 1'b1;
    rep_addr = 3'd6;
    @(negedge clk);
    total++;
    if (rep_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rtf_gnt got=%b exp=1", rep_gnt);
    end
    sb_q.push_back({1'b1, 32'hCAFE_0006});
    tick();
    rep_req   = 1'b0;
    flush_req = 1'b1;
    @(negedge clk);
    total++;
    if ({rep_gnt, busy, rsp_valid} !== 3'b001) begin
      bad++;
      $display("FAIL rtf_n got=%b exp=001", {rep_gnt, busy, rsp_valid});
    end
    tick();
    @(negedge clk);
    total++;
    if ({flush_ack, busy} !== 2'b11) begin
      bad++;
      $display("FAIL rtf_flush got=%b exp=11", {flush_ack, busy});
    end
    clr_ref();
    tick();
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rtf_held_active got=%b exp=0", busy);
    end
    tick();
    flush_req = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL rtf_reflush got=%b exp=1", busy);
    end
    tick();
    idle();
    @(negedge clk);
    tick();
  endtask

  task automatic test_reset_mid();
    fill_req  = 1'b1;
    fill_addr = 3'd7;
    fill_data = 32'h7777_0007;
    @(negedge clk);
    tick();
    idle();
    rep_req  = 1'b1;
    rep_addr = 3'd7;
    @(negedge clk);
    total++;
    if (rep_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rmid_gnt got=%b exp=1", rep_gnt);
    end
    tick();
    rep_req = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_drop got=%b exp=0", rsp_valid);
    end
    tick();
    reset = 1'b0;
    clr_ref();
    @(negedge clk);
    total++;
    if ({rsp_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL rmid_after got=%b exp=00", {rsp_valid, busy});
    end
    tick();
    rep_req  = 1'b1;
    rep_addr = 3'd7;
    @(negedge clk);
    total++;
    if (rep_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rmid_regnt got=%b exp=1", rep_gnt);
    end
    sb_q.push_back({1'b0, 32'h0});
    tick();
    idle();
    @(negedge clk);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    for (int i = 0; i < 8; i++) begin
      bram[i]    = 32'hDEAD_0000 + 32'(i);
      ref_mem[i] = '0;
    end
    clr_ref();
    test_reset();
    test_fill_replay();
    test_miss();
    test_back_to_back();
    test_flush();
    test_replay_then_flush();
    test_reset_mid();
    for (int i = 0; i < 4 && sb_q.size() != 0; i++) tick();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d exp=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
